// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM fade controller.
// Build option: PWM_FADE_BREATHE_EN enables the breathing mode in pwm_fade_ctrl.
package pwm_pkg;

  localparam int R_DEFAULT  = 10;
  localparam int IW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    BREATHE = 2'd2
  } fade_state_t;

  // One saturating move of cur toward tgt; never passes tgt in either direction.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] tgt,
                                           input logic [31:0] step);
    logic [31:0] res;
    if (tgt >= cur) begin
      if ((tgt - cur) <= step) res = tgt;
      else                     res = cur + step;
    end else begin
      if ((cur - tgt) <= step) res = tgt;
      else                     res = cur - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_fade_ctrl_tick_gen.sv
// Step-interval counter: strobes once every interval+1 enabled clocks.
module fade_tick_gen
  import pwm_pkg::*;
#(
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [IW-1:0] interval,
  output logic          tick
);

  logic [IW-1:0] count;

  assign tick = enable && (count == interval);

  // Interval counter; wraps to zero on the strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {IW{1'b0}};
    end else if (clear) begin
      count <= {IW{1'b0}};
    end else if (tick) begin
      count <= {IW{1'b0}};
    end else if (enable) begin
      count <= count + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle ramp generator feeding a PWM duty input.
// Build option: define PWM_FADE_BREATHE_EN for the cmd_breathe port and BREATHE mode.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int R  = R_DEFAULT,
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [R:0]    cmd_target,
  input  logic [R-1:0]  cmd_step,
  input  logic [IW-1:0] cmd_interval,
`ifdef PWM_FADE_BREATHE_EN
  input  logic          cmd_breathe,
`endif
  input  logic          abort,
  output logic [R:0]    duty,
  output logic          busy,
  output logic          done
);

  localparam logic [R:0]   DUTY_MAX  = {1'b1, {R{1'b0}}};
  localparam logic [R:0]   DUTY_ZERO = {(R+1){1'b0}};
  localparam logic [R-1:0] STEP_ONE  = {{(R-1){1'b0}}, 1'b1};

  fade_state_t   state;
  logic [R:0]    target_r;
  logic [R-1:0]  step_r;
  logic [IW-1:0] interval_r;
  logic [R:0]    goal;
  logic [R:0]    clamped;
  logic [R-1:0]  step_eff;
  logic [31:0]   next_full;
  logic [R:0]    next_duty;
  logic          reached;
  logic          accept;
  logic          ramping;
  logic          step_due;

`ifdef PWM_FADE_BREATHE_EN
  // In breathe mode the goal alternates between the target and zero.
  logic [R:0]    goal_r;
  assign goal = goal_r;
`else
  assign goal = target_r;
`endif

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign ramping   = (state == RAMP) || (state == BREATHE);

  // Command normalisation and next-step datapath.
  always_comb begin
    clamped   = (cmd_target > DUTY_MAX) ? DUTY_MAX : cmd_target;
    step_eff  = (cmd_step == {R{1'b0}}) ? STEP_ONE : cmd_step;
    next_full = sat_step(32'(duty), 32'(goal), 32'(step_r));
    next_duty = next_full[R:0];
    reached   = (next_full == 32'(goal));
  end

  fade_tick_gen #(.IW(IW)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .enable   (ramping),
    .interval (interval_r),
    .tick     (step_due)
  );

  // Control FSM with registered duty/busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      duty       <= DUTY_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
      target_r   <= DUTY_ZERO;
      step_r     <= {R{1'b0}};
      interval_r <= {IW{1'b0}};
`ifdef PWM_FADE_BREATHE_EN
      goal_r     <= DUTY_ZERO;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target_r   <= clamped;
            step_r     <= step_eff;
            interval_r <= cmd_interval;
`ifdef PWM_FADE_BREATHE_EN
            goal_r     <= clamped;
`endif
            if (clamped == duty) begin
              done <= 1'b1;
            end
`ifdef PWM_FADE_BREATHE_EN
            // A zero target cannot breathe; it degenerates to a plain ramp.
            else if (cmd_breathe && (clamped != DUTY_ZERO)) begin
              state <= BREATHE;
              busy  <= 1'b1;
            end
`endif
            else begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_due) begin
            duty <= next_duty;
            if (reached) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`ifdef PWM_FADE_BREATHE_EN
        BREATHE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_due) begin
            duty <= next_duty;
            if (reached) begin
              goal_r <= (goal_r == DUTY_ZERO) ? target_r : DUTY_ZERO;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl against a cycle-count reference model.
module tb_pwm_fade_ctrl;

  localparam int R    = 10;
  localparam int IW   = 32;
  localparam int DMAX = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [R:0]    cmd_target;
  logic [R-1:0]  cmd_step;
  logic [IW-1:0] cmd_interval;
`ifdef PWM_FADE_BREATHE_EN
  logic          cmd_breathe;
`endif
  logic          abort;
  logic [R:0]    duty;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int m_duty   = 0;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.R(R), .IW(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_step     (cmd_step),
    .cmd_interval (cmd_interval),
`ifdef PWM_FADE_BREATHE_EN
    .cmd_breathe  (cmd_breathe),
`endif
    .abort        (abort),
    .duty         (duty),
    .busy         (busy),
    .done         (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [R:0] obs, input int exp);
    checks++;
    assert (obs === exp[R:0]) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Move cur toward goal by s without passing it.
  function automatic int ref_step(input int cur, input int goal, input int s);
    if (cur < goal) return (cur + s > goal) ? goal : cur + s;
    else            return (cur - s < goal) ? goal : cur - s;
  endfunction

  // Issue one command and follow it edge by edge; abort_at>0 aborts on that step.
  task automatic fade(input int tgt, input int stp, input int ivl,
                      input int abort_at, input bit noisy);
    int t, s, e, nsteps;
    bit is_step, do_abort, fin;
    t = (tgt > DMAX) ? DMAX : tgt;
    s = (stp == 0) ? 1 : stp;
    cmd_valid    = 1'b1;
    cmd_target   = 11'(tgt);
    cmd_step     = 10'(stp);
    cmd_interval = 32'(ivl);
    abort        = 1'($urandom_range(0, 1));
    chk1("ready_before_accept", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    if (t == m_duty) begin
      chk1("same_done", done, 1'b1);
      chk1("same_busy", busy, 1'b0);
      chkd("same_duty", duty, m_duty);
      return;
    end
    chk1("accept_busy", busy, 1'b1);
    chk1("accept_done", done, 1'b0);
    chkd("accept_duty", duty, m_duty);
    e = 0;
    nsteps = 0;
    while (e < 20000) begin
      e++;
      is_step  = (e % (ivl + 1)) == 0;
      do_abort = is_step && (nsteps + 1 == abort_at);
      abort    = do_abort;
      if (noisy) begin
        cmd_valid    = 1'b1;
        cmd_target   = 11'($urandom);
        cmd_step     = 10'($urandom);
        cmd_interval = $urandom_range(0, 3);
      end
      tick();
      abort     = 1'b0;
      cmd_valid = 1'b0;
      if (do_abort) begin
        chkd("abort_duty", duty, m_duty);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_ready", cmd_ready, 1'b1);
        return;
      end
      if (is_step) begin
        nsteps++;
        m_duty = ref_step(m_duty, t, s);
      end
      fin = (m_duty == t);
      chkd("ramp_duty", duty, m_duty);
      chk1("ramp_busy", busy, !fin);
      chk1("ramp_done", done, fin);
      if (fin) return;
      chk1("ramp_ready", cmd_ready, 1'b0);
    end
    chk1("ramp_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_target   = 11'd0;
    cmd_step     = 10'd0;
    cmd_interval = 32'd0;
    abort        = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
    cmd_breathe  = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chkd("reset_duty", duty, 0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_ready", cmd_ready, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk1("ready_after_reset", cmd_ready, 1'b1);

    fade(100, 10, 4, 0, 1'b0);
    fade(5, 30, 0, 0, 1'b1);
    fade(1020, 1015, 0, 0, 1'b0);
    fade(2000, 0, 0, 0, 1'b0);
    fade(0, 1023, 0, 0, 1'b0);
    fade(100, 20, 1, 3, 1'b1);
    fade(40, 5, 3, 0, 1'b0);
    fade(300, 64, 2, 0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      fade($urandom_range(0, 2047),
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300),
           $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
           1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a ramp wipes everything, including a pending done.
    t = (m_duty == 500) ? 600 : 500;
    cmd_valid    = 1'b1;
    cmd_target   = 11'(t);
    cmd_step     = 10'd7;
    cmd_interval = 32'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    m_duty = 0;
    chkd("midreset_duty", duty, 0);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_done", done, 1'b0);
    tick();
    chk1("midreset_done_later", done, 1'b0);

`ifdef PWM_FADE_BREATHE_EN
    begin
      int goal;
      cmd_valid    = 1'b1;
      cmd_breathe  = 1'b1;
      cmd_target   = 11'd20;
      cmd_step     = 10'd10;
      cmd_interval = 32'd0;
      tick();
      cmd_breathe = 1'b0;
      goal = 20;
      for (int i = 0; i < 16; i++) begin
        cmd_valid  = 1'b1;
        cmd_target = 11'($urandom);
        tick();
        m_duty = ref_step(m_duty, goal, 10);
        if (m_duty == goal) goal = (goal == 0) ? 20 : 0;
        chkd("breathe_duty", duty, m_duty);
        chk1("breathe_busy", busy, 1'b1);
        chk1("breathe_done", done, 1'b0);
      end
      cmd_valid = 1'b0;
      abort     = 1'b1;
      tick();
      abort = 1'b0;
      chkd("breathe_abort_duty", duty, m_duty);
      chk1("breathe_abort_busy", busy, 1'b0);
      chk1("breathe_abort_done", done, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
